// File: rtl/decodificador_botoes_pkg.sv
// Shared definitions for the button event decoder: state encoding, default
// timing parameters and the event bundle also consumed by controlador_estados.
package decodificador_botoes_pkg;

  localparam int unsigned T_LONGO_PADRAO = 25_000_000;
  localparam int unsigned JANELA_PADRAO  = 2_500_000;

  localparam logic [2:0] OCIOSO        = 3'd0;
  localparam logic [2:0] PRESS_B1      = 3'd1;
  localparam logic [2:0] PRESS_B2      = 3'd2;
  localparam logic [2:0] AMBOS         = 3'd3;
  localparam logic [2:0] ESPERA_SOLTAR = 3'd4;

  typedef struct packed {
    logic ambos;
    logic b2_longo;
    logic b2_curto;
    logic b1_longo;
    logic b1_curto;
  } eventos_t;

  localparam eventos_t SEM_EVENTOS = '0;

endpackage

// File: rtl/decodificador_botoes_contador.sv
// Saturating up-counter for the held-sample count of the pressed button.
module contador_saturado #(
  parameter int unsigned LIMITE = 8,
  parameter int          W      = $clog2(LIMITE + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         limpa,
  input  logic         incrementa,
  output logic [W-1:0] valor,
  output logic         cheio
);

  localparam logic [W-1:0] LIMITE_W = W'(LIMITE);

  assign cheio = (valor == LIMITE_W);

  // Clear wins over increment; once at the limit the count holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      valor <= '0;
    end else if (limpa) begin
      valor <= '0;
    end else if (incrementa && !cheio) begin
      valor <= valor + W'(1);
    end
  end

endmodule

// File: rtl/decodificador_botoes.sv
// Turns debounced b1/b2 levels into one-cycle short, long and combo pulses.
//
// state         | meaning
// OCIOSO        | no button held, waiting for a press
// PRESS_B1      | b1 held alone, counting samples
// PRESS_B2      | b2 held alone, counting samples
// AMBOS         | combo recognised, ambos pulse is out
// ESPERA_SOLTAR | event already issued, waiting for both buttons released
module decodificador_botoes
  import decodificador_botoes_pkg::*;
#(
  parameter int unsigned T_LONGO = T_LONGO_PADRAO,
  parameter int unsigned JANELA  = JANELA_PADRAO
) (
  input  logic clk,
  input  logic rst,
  input  logic b1,
  input  logic b2,
  output logic b1_curto,
  output logic b2_curto,
  output logic b1_longo,
  output logic b2_longo,
  output logic ambos
);

  localparam int W = $clog2(T_LONGO + 1);
  localparam logic [W-1:0] JANELA_W   = W'(JANELA);
  localparam logic [W-1:0] ULTIMO_PRE = W'(T_LONGO - 1);

  if (!(JANELA >= 1 && JANELA < T_LONGO && T_LONGO >= 2)) begin : g_param_invalido
    $error("decodificador_botoes: requires 1 <= JANELA < T_LONGO and T_LONGO >= 2");
  end

  logic [2:0]   estado, prox_estado;
  eventos_t     eventos, prox_eventos;
  logic         limpa, incrementa;
  logic [W-1:0] valor;
  logic         cheio;
  logic         premido, outro;

  contador_saturado #(
    .LIMITE (T_LONGO),
    .W      (W)
  ) u_contador (
    .clk        (clk),
    .rst        (rst),
    .limpa      (limpa),
    .incrementa (incrementa),
    .valor      (valor),
    .cheio      (cheio)
  );

  assign premido = (estado == PRESS_B2) ? b2 : b1;
  assign outro   = (estado == PRESS_B2) ? b1 : b2;

  // valor counts the samples seen before this one, so the current sample is valor+1.
  always_comb begin
    prox_estado  = estado;
    prox_eventos = SEM_EVENTOS;
    limpa        = 1'b0;
    incrementa   = 1'b0;
    case (estado)
      OCIOSO: begin
        if (b1 && b2) begin
          prox_estado        = AMBOS;
          prox_eventos.ambos = 1'b1;
        end else if (b1) begin
          prox_estado = PRESS_B1;
          incrementa  = 1'b1;
        end else if (b2) begin
          prox_estado = PRESS_B2;
          incrementa  = 1'b1;
        end
      end
      PRESS_B1, PRESS_B2: begin
        if (!premido) begin
          limpa       = 1'b1;
          prox_estado = outro ? ESPERA_SOLTAR : OCIOSO;
          if (estado == PRESS_B1) prox_eventos.b1_curto = 1'b1;
          else                    prox_eventos.b2_curto = 1'b1;
        end else if (outro && (valor < JANELA_W)) begin
          limpa              = 1'b1;
          prox_estado        = AMBOS;
          prox_eventos.ambos = 1'b1;
        end else if ((valor == ULTIMO_PRE) || cheio) begin
          limpa       = 1'b1;
          prox_estado = ESPERA_SOLTAR;
          if (estado == PRESS_B1) prox_eventos.b1_longo = 1'b1;
          else                    prox_eventos.b2_longo = 1'b1;
        end else begin
          incrementa = 1'b1;
        end
      end
      AMBOS: begin
        limpa       = 1'b1;
        prox_estado = ESPERA_SOLTAR;
      end
      ESPERA_SOLTAR: begin
        limpa = 1'b1;
        if (!b1 && !b2) prox_estado = OCIOSO;
      end
      default: begin
        limpa       = 1'b1;
        prox_estado = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado  <= OCIOSO;
      eventos <= SEM_EVENTOS;
    end else begin
      estado  <= prox_estado;
      eventos <= prox_eventos;
    end
  end

  assign b1_curto = eventos.b1_curto;
  assign b2_curto = eventos.b2_curto;
  assign b1_longo = eventos.b1_longo;
  assign b2_longo = eventos.b2_longo;
  assign ambos    = eventos.ambos;

endmodule

// File: tb/tb_decodificador_botoes.sv
// Scoreboard bench for decodificador_botoes with T_LONGO=8, JANELA=2.
module tb_decodificador_botoes;

  localparam int T_LONGO = 8;
  localparam int JANELA  = 2;

  localparam logic [4:0] NADA = 5'b00000;
  localparam logic [4:0] C1   = 5'b00001;
  localparam logic [4:0] L1   = 5'b00010;
  localparam logic [4:0] C2   = 5'b00100;
  localparam logic [4:0] L2   = 5'b01000;
  localparam logic [4:0] AM   = 5'b10000;

  logic clk, rst, b1, b2;
  logic b1_curto, b2_curto, b1_longo, b2_longo, ambos;
  logic [4:0] saida;

  logic [4:0] sb[$];
  int n_checks = 0;
  int n_errors = 0;

  // reference model: 0 idle, 1 b1 held, 2 b2 held, 3 combo, 4 wait release
  int m_st  = 0;
  int m_cnt = 0;

  decodificador_botoes #(.T_LONGO(T_LONGO), .JANELA(JANELA)) dut (
    .clk      (clk),
    .rst      (rst),
    .b1       (b1),
    .b2       (b2),
    .b1_curto (b1_curto),
    .b2_curto (b2_curto),
    .b1_longo (b1_longo),
    .b2_longo (b2_longo),
    .ambos    (ambos)
  );

  assign saida = {ambos, b2_longo, b2_curto, b1_longo, b1_curto};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pk(input logic r, input logic v1, input logic v2,
                                    input logic [4:0] e);
    return {r, v1, v2, e};
  endfunction

  task automatic drive(input logic [7:0] s);
    rst = s[7];
    b1  = s[6];
    b2  = s[5];
    sb.push_back(s[4:0]);
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic v1, input logic v2, output logic [4:0] e);
    logic held, other;
    int   idx;
    e = NADA;
    case (m_st)
      0: begin
        if (v1 && v2) begin e[4] = 1'b1; m_st = 3; end
        else if (v1) begin m_st = 1; m_cnt = 1; end
        else if (v2) begin m_st = 2; m_cnt = 1; end
      end
      1, 2: begin
        idx   = m_st - 1;
        held  = (m_st == 1) ? v1 : v2;
        other = (m_st == 1) ? v2 : v1;
        if (!held) begin
          e[2*idx] = 1'b1;
          m_st = other ? 4 : 0;
        end else begin
          m_cnt++;
          if (other && m_cnt <= JANELA) begin e[4] = 1'b1; m_st = 3; end
          else if (m_cnt >= T_LONGO) begin e[2*idx+1] = 1'b1; m_st = 4; end
        end
      end
      3: m_st = 4;
      default: if (!v1 && !v2) m_st = 0;
    endcase
  endtask

  task automatic test_reset();
    logic [7:0] seq[$];
    logic [4:0] e;
    for (int i = 0; i < 3; i++) seq.push_back(pk(1, 1, 1, NADA));
    seq.push_back(pk(1, 0, 0, NADA));
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb.pop_front();
      n_checks++;
      if (saida !== e) begin
        n_errors++;
        $display("FAIL reset step %0d: observed %b expected %b", i, saida, e);
      end
    end
  endtask

  task automatic test_curto();
    logic [7:0] seq[$];
    logic [4:0] e;
    for (int i = 0; i < 3; i++) seq.push_back(pk(0, 1, 0, NADA));
    seq.push_back(pk(0, 0, 0, C1));
    seq.push_back(pk(0, 0, 0, NADA));
    for (int i = 0; i < 2; i++) seq.push_back(pk(0, 0, 1, NADA));
    seq.push_back(pk(0, 0, 0, C2));
    seq.push_back(pk(0, 0, 0, NADA));
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb.pop_front();
      n_checks++;
      if (saida !== e) begin
        n_errors++;
        $display("FAIL curto step %0d: observed %b expected %b", i, saida, e);
      end
    end
  endtask

  task automatic test_longo();
    logic [7:0] seq[$];
    logic [4:0] e;
    for (int i = 1; i <= 20; i++) seq.push_back(pk(0, 1, 0, (i == 8) ? L1 : NADA));
    seq.push_back(pk(0, 0, 0, NADA));
    for (int i = 0; i < 3; i++) seq.push_back(pk(0, 1, 0, NADA));
    seq.push_back(pk(0, 0, 0, C1));
    for (int i = 1; i <= 9; i++) seq.push_back(pk(0, 0, 1, (i == 8) ? L2 : NADA));
    seq.push_back(pk(0, 0, 0, NADA));
    seq.push_back(pk(0, 0, 0, NADA));
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb.pop_front();
      n_checks++;
      if (saida !== e) begin
        n_errors++;
        $display("FAIL longo step %0d: observed %b expected %b", i, saida, e);
      end
    end
  endtask

  task automatic test_combo();
    logic [7:0] seq[$];
    logic [4:0] e;
    // b2 joins on the 2nd b1 sample: count equals JANELA, still a combo
    seq.push_back(pk(0, 1, 0, NADA));
    seq.push_back(pk(0, 1, 1, AM));
    seq.push_back(pk(0, 1, 1, NADA));
    seq.push_back(pk(0, 0, 0, NADA));
    // both in the same sample
    seq.push_back(pk(0, 1, 1, AM));
    seq.push_back(pk(0, 1, 1, NADA));
    seq.push_back(pk(0, 0, 1, NADA));
    seq.push_back(pk(0, 0, 0, NADA));
    // b1 joins on the 3rd b2 sample: past the window, press continues to long
    seq.push_back(pk(0, 0, 1, NADA));
    seq.push_back(pk(0, 0, 1, NADA));
    for (int i = 3; i <= 8; i++) seq.push_back(pk(0, 1, 1, (i == 8) ? L2 : NADA));
    seq.push_back(pk(0, 0, 0, NADA));
    seq.push_back(pk(0, 0, 0, NADA));
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb.pop_front();
      n_checks++;
      if (saida !== e) begin
        n_errors++;
        $display("FAIL combo step %0d: observed %b expected %b", i, saida, e);
      end
    end
  endtask

  task automatic test_soltar_prioridade();
    logic [7:0] seq[$];
    logic [4:0] e;
    for (int i = 0; i < 4; i++) seq.push_back(pk(0, 1, 0, NADA));
    seq.push_back(pk(0, 1, 1, NADA));
    seq.push_back(pk(0, 0, 1, C1));
    for (int i = 0; i < 3; i++) seq.push_back(pk(0, 0, 1, NADA));
    seq.push_back(pk(0, 0, 0, NADA));
    seq.push_back(pk(0, 0, 0, NADA));
    // release beats combo even inside the window
    seq.push_back(pk(0, 1, 0, NADA));
    seq.push_back(pk(0, 0, 1, C1));
    seq.push_back(pk(0, 0, 1, NADA));
    seq.push_back(pk(0, 0, 0, NADA));
    seq.push_back(pk(0, 0, 0, NADA));
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb.pop_front();
      n_checks++;
      if (saida !== e) begin
        n_errors++;
        $display("FAIL soltar_prioridade step %0d: observed %b expected %b", i, saida, e);
      end
    end
  endtask

  task automatic test_reset_meio();
    logic [7:0] seq[$];
    logic [4:0] e;
    for (int i = 0; i < 4; i++) seq.push_back(pk(0, 1, 0, NADA));
    seq.push_back(pk(1, 1, 0, NADA));
    for (int i = 1; i <= 10; i++) seq.push_back(pk(0, 1, 0, (i == 8) ? L1 : NADA));
    seq.push_back(pk(0, 0, 0, NADA));
    seq.push_back(pk(0, 0, 0, NADA));
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb.pop_front();
      n_checks++;
      if (saida !== e) begin
        n_errors++;
        $display("FAIL reset_meio step %0d: observed %b expected %b", i, saida, e);
      end
    end
  endtask

  task automatic test_aleatorio();
    logic v1, v2;
    logic [4:0] e, o, ant;
    int st_ant;
    drive(pk(1, 0, 0, NADA));
    e = sb.pop_front();
    n_checks++;
    if (saida !== e) begin
      n_errors++;
      $display("FAIL aleatorio_reset: observed %b expected %b", saida, e);
    end
    m_st = 0;
    m_cnt = 0;
    v1 = 1'b0;
    v2 = 1'b0;
    ant = NADA;
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(7) == 0) v1 = ~v1;
      if ($urandom_range(7) == 0) v2 = ~v2;
      st_ant = m_st;
      model_step(v1, v2, e);
      drive(pk(0, v1, v2, e));
      e = sb.pop_front();
      o = saida;
      n_checks++;
      if (o !== e) begin
        n_errors++;
        $display("FAIL aleatorio_modelo cycle %0d: observed %b expected %b", k, o, e);
      end
      n_checks++;
      if ($countones(o) > 1) begin
        n_errors++;
        $display("FAIL aleatorio_exclusivo cycle %0d: observed %b expected at most one bit", k, o);
      end
      n_checks++;
      if ((o & ant) != 5'b0) begin
        n_errors++;
        $display("FAIL aleatorio_consecutivo cycle %0d: observed %b after %b expected no repeat", k, o, ant);
      end
      if (st_ant == 4) begin
        n_checks++;
        if (o !== NADA) begin
          n_errors++;
          $display("FAIL aleatorio_espera cycle %0d: observed %b expected 00000", k, o);
        end
      end
      ant = o;
    end
  endtask

  initial begin
    rst = 1'b1;
    b1  = 1'b0;
    b2  = 1'b0;
    @(negedge clk);
    test_reset();
    test_curto();
    test_longo();
    test_combo();
    test_soltar_prioridade();
    test_reset_meio();
    test_aleatorio();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decodificador_botoes.md
DECODIFICADOR_BOTOES -- requirements
Module: decodificador_botoes

Interface
REQ-001 The block SHALL expose parameter T_LONGO, default 25_000_000, the number of consecutive held samples that qualify a long press.
REQ-002 The block SHALL expose parameter JANELA, default 2_500_000, the maximum held-sample count of the first button at which a second-button press still forms a combo.
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have ports b1 and b2, input, 1 bit each, debounced button levels from controlador_botao, 1 = pressed.
REQ-006 The block SHALL have ports b1_curto and b2_curto, output, 1 bit each, one-cycle short-press pulses.
REQ-007 The block SHALL have ports b1_longo and b2_longo, output, 1 bit each, one-cycle long-press pulses.
REQ-008 The block SHALL have port ambos, output, 1 bit, a one-cycle combo-press pulse.

Function
REQ-009 The block SHALL implement the states OCIOSO, PRESS_B1, PRESS_B2, AMBOS and ESPERA_SOLTAR.
REQ-010 All outputs SHALL be registered, at most one output SHALL be high in any cycle, and each event SHALL be high exactly one cycle after the qualifying sample.
REQ-011 In OCIOSO:
- b1=1 and b2=1 in the same sample -> AMBOS.
- b1 only -> PRESS_B1 with held count 1.
- b2 only -> PRESS_B2 with held count 1.
- neither -> stay.
REQ-012 In PRESS_Bx, the count SHALL increment on each high sample of the held button and SHALL saturate at T_LONGO.
REQ-013 In PRESS_Bx, when the other button samples high while count <= JANELA and the held button is still high, the block SHALL go to AMBOS and SHALL emit no bx event.
REQ-014 In PRESS_Bx, when the other button goes high with count > JANELA, it SHALL be ignored and the press SHALL continue.
REQ-015 In PRESS_Bx, when the held button samples low with count < T_LONGO, the block SHALL pulse bx_curto.
- Next state is OCIOSO if the other button is low.
- Next state is ESPERA_SOLTAR if the other button is high; release takes priority over the combo.
REQ-016 In PRESS_Bx, when the held count reaches T_LONGO, the block SHALL pulse bx_longo once and go to ESPERA_SOLTAR.
REQ-017 On entry to AMBOS, the block SHALL pulse ambos once, then go to ESPERA_SOLTAR unconditionally.
REQ-018 In ESPERA_SOLTAR, the block SHALL emit no events and SHALL return to OCIOSO on the first sample with b1=0 and b2=0.
REQ-019 The count width SHALL be $clog2(T_LONGO+1) and SHALL never wrap.
REQ-020 Parameter legality SHALL be 1 <= JANELA < T_LONGO and T_LONGO >= 2, enforced by an elaboration-time check.

Reset
REQ-021 While rst=1 at a clk edge, the state SHALL become OCIOSO, the count 0 and all outputs 0.
REQ-022 A reset mid-press SHALL discard the press.
REQ-023 After reset deassertion, a button that is still held SHALL be treated as a new press starting in OCIOSO.

Structure
REQ-024 A shared package SHALL hold the state encoding and the default values of T_LONGO and JANELA; controlador_estados SHALL import the same package.
REQ-025 The held counter SHALL be a sub-module contador_saturado (inputs: clk, rst, limpa, incrementa; outputs: valor, cheio), instantiated once.
REQ-026 In zanagotchi, this block SHALL sit between controlador_botao and controlador_estados, replacing the raw b1_aux/b2_aux levels with event pulses.

Verification (T_LONGO=8, JANELA=2)
REQ-027 b1 high for 3 cycles then low -> b1_curto high for exactly one cycle, in the cycle after the first low sample; all other outputs stay 0.
REQ-028 b1 high for 20 cycles -> b1_longo high for one cycle, in the cycle after the 8th high sample; no b1_curto on release; the block is back in OCIOSO after release.
REQ-029 Combo cases:
- b1 rises, b2 rises on the 2nd b1 sample -> ambos pulses once and no b1 event.
- Both rising in the same cycle -> ambos pulses once.
REQ-030 b1 held, b2 rises on the 5th b1 sample, b1 released on the 6th -> b1_curto pulses once and ambos stays 0; with b2 still high the block holds ESPERA_SOLTAR until b2 is low.
REQ-031 rst asserted for 1 cycle on the 5th sample of a b1 press, b1 held 10 more cycles -> no event before the new count reaches 8, then b1_longo pulses once.
REQ-032 Stimulus of 10k random cycles on b1/b2 -> the bench SHALL confirm no cycle has two outputs high, no output is high for two consecutive cycles, and no event occurs while in ESPERA_SOLTAR.
